// File: rtl/sha_pkg.sv
// Shared definitions for the SHA message-schedule block: word width, round counts,
// mode encoding, FSM state type and the rotate / sigma helpers used by the
// next-word logic.
package sha_pkg;

    localparam int unsigned N             = 32;
    localparam int unsigned SHA1_ROUNDS   = 80;
    localparam int unsigned SHA256_ROUNDS = 64;

    localparam logic MODE_SHA1   = 1'b0;
    localparam logic MODE_SHA256 = 1'b1;

    typedef logic [N-1:0] word_t;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } sched_state_e;

    // Rotates via a doubled word so no shift amount of N is ever needed.
    function automatic word_t rotl(input word_t x, input int unsigned sh);
        logic [2*N-1:0] d;
        d = {x, x} << sh;
        return d[2*N-1 -: N];
    endfunction

    function automatic word_t rotr(input word_t x, input int unsigned sh);
        logic [2*N-1:0] d;
        d = {x, x} >> sh;
        return d[N-1:0];
    endfunction

    function automatic word_t sha256_s0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t sha256_s1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha_w_next.sv
// Combinational next-word generator for the message schedule.
// Ports:
//   mode_i    - 0 = SHA-1, 1 = SHA-256
//   win_i     - 16-word window, win_i[0] is the oldest word (W_t)
//   w_next_o  - W_t+16 for the selected mode
module sha_w_next
    import sha_pkg::*;
(
    input  logic  mode_i,
    input  word_t win_i [16],
    output word_t w_next_o
);

    word_t sha1_w;
    word_t sha256_w;

    assign sha1_w   = rotl(win_i[13] ^ win_i[8] ^ win_i[2] ^ win_i[0], 1);
    assign sha256_w = sha256_s1(win_i[14]) + win_i[9] + sha256_s0(win_i[1]) + win_i[0];

    assign w_next_o = (mode_i == MODE_SHA256) ? sha256_w : sha1_w;

    // Window taps that neither recurrence reads.
    logic unused_win;
    assign unused_win = ^{win_i[3], win_i[4], win_i[5], win_i[6], win_i[7],
                          win_i[10], win_i[11], win_i[12], win_i[15]};

endmodule

// File: rtl/sha_msg_sched.sv
// Message-schedule generator: accepts one 512-bit block and streams W_0..W_79 (SHA-1)
// or W_0..W_63 (SHA-256) with valid/ready backpressure and an end-of-block flag.
// Optional feature macro: MSG_SCHED_ABORT_EN adds abort_i, which drops a running
// block back to idle.
// Ports:
//   clk, rst_n             - clock, asynchronous active-low reset
//   mode_i                 - schedule mode, captured when a block is accepted
//   blk_valid_i/blk_ready_o/blk_din_i - block handshake; word 0 in the top N bits
//   abort_i                - (MSG_SCHED_ABORT_EN only) cancel the running block
//   w_valid_o/w_ready_i    - word stream handshake
//   w_o, w_idx_o, w_last_o - current word, its round index, final-word flag
//   busy_o                 - a block is being streamed
module sha_msg_sched
    import sha_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned IDX_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode_i,
    input  logic              blk_valid_i,
    output logic              blk_ready_o,
    input  logic [16*N-1:0]   blk_din_i,
`ifdef MSG_SCHED_ABORT_EN
    input  logic              abort_i,
`endif
    output logic              w_valid_o,
    input  logic              w_ready_i,
    output logic [N-1:0]      w_o,
    output logic [IDX_W-1:0]  w_idx_o,
    output logic              w_last_o,
    output logic              busy_o
);

    if (N != sha_pkg::N) begin : g_bad_n
        $error("sha_msg_sched: N must be 32");
    end
    if ((1 << IDX_W) < SHA1_ROUNDS) begin : g_bad_idx_w
        $error("sha_msg_sched: IDX_W too narrow for 80 rounds");
    end

    sched_state_e     state_q, state_d;
    word_t            win_q [16];
    word_t            win_d [16];
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    word_t            w_next;
    logic             last;
    logic             abort;

`ifdef MSG_SCHED_ABORT_EN
    assign abort = abort_i;
`else
    assign abort = 1'b0;
`endif

    sha_w_next u_w_next (
        .mode_i   (mode_q),
        .win_i    (win_q),
        .w_next_o (w_next)
    );

    assign last = (state_q == StRun) &&
                  (((mode_q == MODE_SHA1)   && (cnt_q == IDX_W'(SHA1_ROUNDS - 1))) ||
                   ((mode_q == MODE_SHA256) && (cnt_q == IDX_W'(SHA256_ROUNDS - 1))));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        win_d       = win_q;
        blk_ready_o = 1'b0;
        w_valid_o   = 1'b0;
        busy_o      = 1'b0;

        unique case (state_q)
            StIdle: begin
                blk_ready_o = 1'b1;
                if (blk_valid_i) begin
                    for (int k = 0; k < 16; k++) begin
                        win_d[k] = blk_din_i[(15-k)*N +: N];
                    end
                    mode_d  = mode_i;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                w_valid_o = 1'b1;
                busy_o    = 1'b1;
                // Abort wins over a same-cycle handshake.
                if (abort) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (w_ready_i) begin
                    if (last) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        for (int k = 0; k < 15; k++) begin
                            win_d[k] = win_q[k+1];
                        end
                        win_d[15] = w_next;
                        cnt_d     = cnt_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            mode_q  <= MODE_SHA1;
            for (int k = 0; k < 16; k++) begin
                win_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            win_q   <= win_d;
        end
    end

    assign w_o      = (state_q == StRun) ? win_q[0] : '0;
    assign w_idx_o  = cnt_q;
    assign w_last_o = last;

endmodule

// File: tb/tb_sha_msg_sched.sv
// Directed bench for sha_msg_sched: SHA-1 / SHA-256 streams against a textbook
// W[t] reference, backpressure stability, back-to-back blocks with mode toggling,
// mid-block reset and (with MSG_SCHED_ABORT_EN) abort.
module tb_sha_msg_sched;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         mode;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_din;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w;
    logic [6:0]   w_idx;
    logic         w_last;
    logic         busy;
`ifdef MSG_SCHED_ABORT_EN
    logic         abort;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0]  ref_w [80];
    logic [31:0]  obs_w [80];
    logic [511:0] abc_blk;
    logic [511:0] blk2;

    always #5 clk = ~clk;

    sha_msg_sched #(
        .N     (32),
        .IDX_W (7)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode_i      (mode),
        .blk_valid_i (blk_valid),
        .blk_ready_o (blk_ready),
        .blk_din_i   (blk_din),
`ifdef MSG_SCHED_ABORT_EN
        .abort_i     (abort),
`endif
        .w_valid_o   (w_valid),
        .w_ready_i   (w_ready),
        .w_o         (w),
        .w_idx_o     (w_idx),
        .w_last_o    (w_last),
        .busy_o      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook recurrences indexed by t, independent of the sliding window.
    task automatic build_ref(input bit md, input logic [511:0] blk);
        logic [31:0] a;
        for (int t = 0; t < 16; t++) ref_w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 80; t++) begin
            if (!md) begin
                a = ref_w[t-3] ^ ref_w[t-8] ^ ref_w[t-14] ^ ref_w[t-16];
                ref_w[t] = {a[30:0], a[31]};
            end else begin
                ref_w[t] = (rr(ref_w[t-2], 17) ^ rr(ref_w[t-2], 19) ^ (ref_w[t-2] >> 10))
                         + ref_w[t-7]
                         + (rr(ref_w[t-15], 7) ^ rr(ref_w[t-15], 18) ^ (ref_w[t-15] >> 3))
                         + ref_w[t-16];
            end
        end
    endtask

    // Called at a negedge in idle; returns at the negedge where W_0 should be visible.
    task automatic offer(input bit md, input logic [511:0] blk);
        build_ref(md, blk);
        check("blk_ready_idle", {31'd0, blk_ready}, 32'd1);
        mode      = md;
        blk_din   = blk;
        blk_valid = 1'b1;
        @(negedge clk);
        blk_valid = 1'b0;
        blk_din   = ~blk;
        mode      = ~md;
    endtask

    // stop_kind: 1 = assert reset at beat stop_at, 2 = abort with w_ready at beat stop_at.
    task automatic stream(input bit md, input bit stall, input bit toggle,
                          input int stop_at, input int stop_kind);
        int          k = 0;
        int          cyc = 0;
        int          last_t;
        bit          held = 1'b0;
        bit          done = 1'b0;
        bit          stopped = 1'b0;
        bit          rdy;
        logic [31:0] hw;
        logic [6:0]  hi;
        logic        hl;
        last_t = md ? 63 : 79;
        if (toggle) blk_valid = 1'b1;
        while (!done) begin
            if (cyc >= 2000) begin
                check("stream_timeout", cyc, 32'd0);
                done = 1'b1;
            end else if (!w_valid) begin
                check("w_valid", {31'd0, w_valid}, 32'd1);
                done    = 1'b1;
                stopped = 1'b1;
            end else begin
                if (held) begin
                    check("stall_w", w, hw);
                    check("stall_idx", {25'd0, w_idx}, {25'd0, hi});
                    check("stall_last", {31'd0, w_last}, {31'd0, hl});
                end
                if (k == 0) check("busy", {31'd0, busy}, 32'd1);
                if (toggle && k == 0) check("blk_ready_run", {31'd0, blk_ready}, 32'd0);
                if (k == stop_at) begin
                    stopped = 1'b1;
                    done    = 1'b1;
                    if (stop_kind == 1) begin
                        rst_n = 1'b0;
                        #1;
                        check("rst_w_valid", {31'd0, w_valid}, 32'd0);
                        check("rst_blk_ready", {31'd0, blk_ready}, 32'd1);
                        check("rst_busy", {31'd0, busy}, 32'd0);
                        check("rst_w_idx", {25'd0, w_idx}, 32'd0);
                        @(negedge clk);
                        rst_n = 1'b1;
                    end
`ifdef MSG_SCHED_ABORT_EN
                    if (stop_kind == 2) begin
                        check("abort_idx", {25'd0, w_idx}, k);
                        abort   = 1'b1;
                        w_ready = 1'b1;
                        @(negedge clk);
                        abort   = 1'b0;
                        w_ready = 1'b0;
                        check("abort_w_valid", {31'd0, w_valid}, 32'd0);
                        check("abort_blk_ready", {31'd0, blk_ready}, 32'd1);
                        check("abort_w_idx", {25'd0, w_idx}, 32'd0);
                    end
`endif
                end else begin
                    rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                    if (toggle) mode = ~mode;
                    w_ready = rdy;
                    if (rdy) begin
                        check("w", w, ref_w[k]);
                        check("w_idx", {25'd0, w_idx}, k);
                        check("w_last", {31'd0, w_last}, {31'd0, (k == last_t)});
                        obs_w[k] = w;
                        held     = 1'b0;
                        if (k == last_t) done = 1'b1;
                        k++;
                    end else begin
                        held = 1'b1;
                        hw   = w;
                        hi   = w_idx;
                        hl   = w_last;
                    end
                end
            end
            if (!stopped) begin
                @(negedge clk);
                cyc++;
            end
        end
        w_ready   = 1'b0;
        blk_valid = 1'b0;
        if (!stopped && k == last_t + 1) begin
            check("end_w_valid", {31'd0, w_valid}, 32'd0);
            check("end_blk_ready", {31'd0, blk_ready}, 32'd1);
            check("end_busy", {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        mode      = 1'b0;
        blk_valid = 1'b0;
        blk_din   = '0;
        w_ready   = 1'b0;
`ifdef MSG_SCHED_ABORT_EN
        abort     = 1'b0;
`endif
        abc_blk            = '0;
        abc_blk[511 -: 32] = 32'h61626380;
        abc_blk[31:0]      = 32'h00000018;
        for (int i = 0; i < 16; i++) begin
            blk2[511-32*i -: 32] = (32'h9e3779b9 * (i + 1)) ^ 32'h5a5a0000;
        end

        repeat (3) @(negedge clk);
        check("reset_blk_ready", {31'd0, blk_ready}, 32'd1);
        check("reset_w_valid", {31'd0, w_valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_w", w, 32'd0);
        check("reset_w_idx", {25'd0, w_idx}, 32'd0);
        check("reset_w_last", {31'd0, w_last}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // SHA-1 "abc", no backpressure
        offer(1'b0, abc_blk);
        stream(1'b0, 1'b0, 1'b0, -1, 0);
        check("sha1_w16", obs_w[16], 32'hC2C4C700);

        // SHA-256 "abc", no backpressure
        offer(1'b1, abc_blk);
        stream(1'b1, 1'b0, 1'b0, -1, 0);
        check("sha256_w16", obs_w[16], 32'h61626380);
        check("sha256_w17", obs_w[17], 32'h000F0000);

        // Random backpressure, both modes
        offer(1'b0, blk2);
        stream(1'b0, 1'b1, 1'b0, -1, 0);
        offer(1'b1, blk2);
        stream(1'b1, 1'b1, 1'b0, -1, 0);

        // Back-to-back, mode and blk_valid wiggling during RUN
        offer(1'b0, blk2);
        stream(1'b0, 1'b0, 1'b1, -1, 0);
        offer(1'b1, abc_blk);
        stream(1'b1, 1'b1, 1'b1, -1, 0);

        // Reset mid-block, then a clean restart
        offer(1'b1, blk2);
        stream(1'b1, 1'b0, 1'b0, 30, 1);
        offer(1'b1, blk2);
        stream(1'b1, 1'b0, 1'b0, -1, 0);

`ifdef MSG_SCHED_ABORT_EN
        // Abort at beat 10, then a block accepted with abort held in idle
        offer(1'b0, abc_blk);
        stream(1'b0, 1'b0, 1'b0, 10, 2);
        abort = 1'b1;
        offer(1'b0, blk2);
        abort = 1'b0;
        stream(1'b0, 1'b0, 1'b0, -1, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sha_msg_sched.md
Name: sha_msg_sched

Overview:
Parametrised message-schedule generator for the hash cores. It accepts one 512-bit block through a valid/ready handshake and streams the expanded words W_t, one per accepted output beat. The stream is 80 words in SHA-1 mode or 64 words in SHA-256 mode, selected per block. It feeds the round-function datapath and replaces the fixed SHA-1-only W generator, adding backpressure, mode selection and explicit end-of-block signalling.

Parameters:
N, 32, word width in bits; only 32 is legal and any other value is an elaboration error.
IDX_W, 7, width of the round-index output; must satisfy 2^IDX_W >= 80.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous assert, active-low
mode  in  1  0 = SHA-1, 1 = SHA-256; sampled only on block acceptance
blk_valid  in  1  block offered
blk_ready  out  1  block can be accepted
blk_din  in  16*N  message block; word 0 in bits [16N-1 -: N], word 15 in bits [N-1:0]
w_valid  out  1  w, w_idx and w_last are valid
w_ready  in  1  consumer accepts the current word
w  out  N  schedule word W_t
w_idx  out  IDX_W  t of the current word
w_last  out  1  current word is the final word of the block (t = 79 or 63)
busy  out  1  block in progress (state RUN)

Behaviour:
- Single clock domain on clk. Reset is asynchronous and active-low on rst_n; release is synchronised externally.
- Reset values:
  - state = IDLE; blk_ready = 1.
  - w_valid, w_last, busy = 0.
  - w, w_idx = 0; window = 0; cnt = 0; mode_q = 0.
- Storage is a 16-word window win[0..15]. win[0] is the oldest word. In RUN, win[0..15] = W_cnt..W_cnt+15.
- State IDLE:
  - blk_ready = 1, w_valid = 0.
  - On blk_valid & blk_ready: load win[k] = word k of blk_din, mode_q = mode, cnt = 0, go to RUN.
  - Blocks offered while in RUN are not accepted; blk_ready = 0 there, so blocks never overlap.
- State RUN:
  - w_valid = 1, w = win[0], w_idx = cnt.
  - w_last = 1 when (mode_q = 0 and cnt = 79) or (mode_q = 1 and cnt = 63).
- Latency: the first beat, W_0, is presented in the cycle after block acceptance.
- On w_valid & w_ready, when not last:
  - Shift the window down one word (win[k] <= win[k+1]).
  - win[15] <= next word (definitions below); cnt <= cnt + 1.
- On w_valid & w_ready with w_last = 1: go to IDLE and clear cnt. The window contents are don't-care after this point.
- Next-word definitions (both computed combinationally from the current window):
  - SHA-1: ROTL1(win[13] ^ win[8] ^ win[2] ^ win[0]).
  - SHA-256: s1(win[14]) + win[9] + s0(win[1]) + win[0], modulo 2^32, carries discarded.
  - s0(x) = ROTR7 ^ ROTR18 ^ SHR3; s1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- Stall: while w_valid & !w_ready, w, w_idx, w_last, window and cnt are held unchanged. w_ready may toggle every cycle.
- Back-to-back blocks: a new block is accepted one cycle after the last beat is accepted, because blk_ready rises in IDLE. Minimum gap between blocks is 1 cycle.
- Changes on mode during RUN have no effect.
- Reset asserted mid-block: immediate return to the reset state. The partial stream is discarded and w_valid drops asynchronously.

Optional Feature:
Macro MSG_SCHED_ABORT_EN.
- Defined: adds input port abort (1 bit).
  - abort = 1 in RUN: next state is IDLE, cnt = 0, w_valid = 0 from the next cycle.
  - abort takes priority over a simultaneous w handshake; that beat still counts as consumed by the consumer.
  - abort in IDLE is ignored, and blk acceptance in the same cycle still proceeds.
- Not defined: the abort port is absent, and blocks always run to w_last.

Decomposition:
- Package sha_pkg holds:
  - N and the round-count constants SHA1_ROUNDS = 80, SHA256_ROUNDS = 64;
  - the mode encoding constants MODE_SHA1 = 0, MODE_SHA256 = 1;
  - functions rotl, rotr, sha256_s0, sha256_s1.
- One sub-module, sha_w_next: purely combinational. Inputs are mode_q and the window; output is the next N-bit word.
- The top level holds the FSM, counter and window registers.

Test Plan:
- SHA-1, "abc" padded block (W0 = 0x61626380, W1..W14 = 0, W15 = 0x00000018), w_ready held at 1 -> 80 beats; W16 = 0xC2C4C700; w_last only at w_idx = 79; blk_ready returns the next cycle.
- SHA-256, same block -> 64 beats; W16 = 0x61626380, W17 = 0x000F0000; w_last at w_idx = 63; full stream matches the reference model.
- Random w_ready backpressure (about 50% duty) in both modes -> w, w_idx and w_last stable during stalls; stream identical to the unstalled run.
- Back-to-back SHA-1 block then SHA-256 block, with mode toggling mid-stream -> each block uses the mode sampled at its acceptance; no beat loss; one idle cycle between blocks.
- rst_n asserted at w_idx = 30 -> w_valid = 0 and blk_ready = 1 immediately; the next block restarts at w_idx = 0.
- With MSG_SCHED_ABORT_EN: abort at w_idx = 10 together with w_ready -> IDLE next cycle; the following block streams correctly from W_0.
